// File: rtl/rat_int_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : rat_int_ctrl
//  Purpose  : Interrupt controller for the RAT MCU. Merges up to NUM_SRC
//             edge-triggered peripheral interrupt sources onto the single
//             MCU INT input. Sources are edge-latched into a pending vector,
//             masked, and arbitrated by fixed priority (lowest index wins).
//             INT is held until firmware acknowledges it, then forced low
//             for GAP_CYCLES cycles so the MCU always sees a falling level
//             between services.
//  Ports    : CLK       system clock, rising edge
//             RESET_N   asynchronous active-low reset
//             IRQ       raw interrupt sources (synchronous to CLK)
//             PORT_ID   MCU port address
//             OUT_PORT  MCU output data
//             IO_STRB   MCU output strobe (one cycle per OUT)
//             IN_DATA   read data for the addressed port (combinational)
//             IN_SEL    high when PORT_ID addresses a readable port
//             INT       registered interrupt request to the MCU
//  Revision : 1.0  initial release
// ============================================================================
module rat_int_ctrl #(
    parameter int         NUM_SRC      = 8,
    parameter logic [7:0] MASK_PORT_ID = 8'h20,
    parameter logic [7:0] STAT_PORT_ID = 8'h21,
    parameter logic [7:0] PEND_PORT_ID = 8'h22,
    parameter logic [7:0] ACK_PORT_ID  = 8'h23,
    parameter int         GAP_CYCLES   = 2
) (
    input  logic               CLK,
    input  logic               RESET_N,
    input  logic [NUM_SRC-1:0] IRQ,
    input  logic [7:0]         PORT_ID,
    input  logic [7:0]         OUT_PORT,
    input  logic               IO_STRB,
    output logic [7:0]         IN_DATA,
    output logic               IN_SEL,
    output logic               INT
);

    localparam int GAP_W = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES + 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ASSERT = 2'd1,
        ST_GAP    = 2'd2
    } state_t;

    state_t             state;
    logic [NUM_SRC-1:0] irq_q;
    logic [NUM_SRC-1:0] mask;
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] elig;
    logic [NUM_SRC-1:0] ack_clr;
    logic [2:0]         cur_id;
    logic [2:0]         winner;
    logic [GAP_W-1:0]   gap_cnt;
    logic               mask_wr;
    logic               ack_wr;
    logic               cur_enabled;

    // ------------------------------------------------------------------
    // Bus decode and edge detection
    // ------------------------------------------------------------------
    assign mask_wr = IO_STRB && (PORT_ID == MASK_PORT_ID);
    assign ack_wr  = IO_STRB && (PORT_ID == ACK_PORT_ID);
    assign rise    = IRQ & ~irq_q;
    assign elig    = pending & mask;

    // Lowest set index of elig; scanning downward lets the lowest win.
    always_comb begin
        winner = 3'd0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (elig[i]) begin
                winner = 3'(i);
            end
        end
    end

    // Only the source currently being serviced is cleared, and only when the
    // ack arrives while INT is actually asserted.
    always_comb begin
        ack_clr = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            ack_clr[i] = (state == ST_ASSERT) && ack_wr && (cur_id == 3'(i));
        end
    end

    always_comb begin
        cur_enabled = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (cur_id == 3'(i)) begin
                cur_enabled = mask[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Source capture and mask register
    // ------------------------------------------------------------------
    // irq_q resets to all ones so a source already high when reset is
    // released is not mistaken for a fresh edge.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            irq_q   <= '1;
            pending <= '0;
            mask    <= '0;
        end else begin
            irq_q   <= IRQ;
            // A new edge in the same cycle as the ack keeps the source pending.
            pending <= (pending & ~ack_clr) | rise;
            if (mask_wr) begin
                mask <= OUT_PORT[NUM_SRC-1:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Service FSM; INT is a registered copy of (state == ST_ASSERT)
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state   <= ST_IDLE;
            cur_id  <= 3'd0;
            gap_cnt <= '0;
            INT     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|elig) begin
                        cur_id <= winner;
                        state  <= ST_ASSERT;
                        INT    <= 1'b1;
                    end
                end
                ST_ASSERT: begin
                    // cur_id stays frozen here: no preemption by higher
                    // priority arrivals. Ack takes precedence over withdraw.
                    if (ack_wr) begin
                        gap_cnt <= GAP_LOAD;
                        state   <= ST_GAP;
                        INT     <= 1'b0;
                    end else if (!cur_enabled) begin
                        state <= ST_IDLE;
                        INT   <= 1'b0;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt <= GAP_LAST) begin
                        gap_cnt <= '0;
                        state   <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_LAST;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    INT   <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Read mux, purely combinational on PORT_ID, no side effects
    // ------------------------------------------------------------------
    always_comb begin
        IN_SEL  = 1'b0;
        IN_DATA = 8'h00;
        if (PORT_ID == MASK_PORT_ID) begin
            IN_SEL  = 1'b1;
            IN_DATA = 8'(mask);
        end else if (PORT_ID == STAT_PORT_ID) begin
            IN_SEL  = 1'b1;
            IN_DATA = {(state == ST_ASSERT), 4'b0000, cur_id};
        end else if (PORT_ID == PEND_PORT_ID) begin
            IN_SEL  = 1'b1;
            IN_DATA = 8'(pending);
        end
    end

    // Data bits above the implemented sources are deliberately dropped.
    generate
        if (NUM_SRC < 8) begin : g_unused_data
            logic unused_out_hi;
            assign unused_out_hi = ^OUT_PORT[7:NUM_SRC];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_rat_int_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rat_int_ctrl
//  Purpose  : Self-checking bench for rat_int_ctrl. Directed scenarios plus a
//             randomized phase, all compared against a behavioural model of
//             the controller kept in this file.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rat_int_ctrl;

    localparam int GAP_CYCLES = 2;
    localparam int MODE_IDLE  = 0;
    localparam int MODE_SERV  = 1;
    localparam int MODE_GAP   = 2;

    logic       CLK;
    logic       RESET_N;
    logic [7:0] IRQ;
    logic [7:0] PORT_ID;
    logic [7:0] OUT_PORT;
    logic       IO_STRB;
    logic [7:0] IN_DATA;
    logic       IN_SEL;
    logic       INT;

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model state
    logic [7:0] m_pend;
    logic [7:0] m_mask;
    logic [7:0] m_prev;
    int         m_mode;
    int         m_cur;
    int         m_gap;

    rat_int_ctrl #(
        .NUM_SRC     (8),
        .MASK_PORT_ID(8'h20),
        .STAT_PORT_ID(8'h21),
        .PEND_PORT_ID(8'h22),
        .ACK_PORT_ID (8'h23),
        .GAP_CYCLES  (GAP_CYCLES)
    ) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .IRQ     (IRQ),
        .PORT_ID (PORT_ID),
        .OUT_PORT(OUT_PORT),
        .IO_STRB (IO_STRB),
        .IN_DATA (IN_DATA),
        .IN_SEL  (IN_SEL),
        .INT     (INT)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %02h expected %02h at %0t", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    function automatic int lowest(input logic [7:0] v);
        for (int i = 0; i < 8; i++) begin
            if (v[i]) return i;
        end
        return 0;
    endfunction

    function automatic logic exp_sel(input logic [7:0] pid);
        return (pid == 8'h20) || (pid == 8'h21) || (pid == 8'h22);
    endfunction

    function automatic logic [7:0] exp_read(input logic [7:0] pid);
        logic [7:0] cur8;
        cur8 = 8'(m_cur);
        case (pid)
            8'h20:   return m_mask;
            8'h21:   return ((m_mode == MODE_SERV) ? 8'h80 : 8'h00) + cur8;
            8'h22:   return m_pend;
            default: return 8'h00;
        endcase
    endfunction

    task automatic model_reset();
        m_pend = 8'h00;
        m_mask = 8'h00;
        m_prev = 8'hFF;
        m_mode = MODE_IDLE;
        m_cur  = 0;
        m_gap  = 0;
    endtask

    // One clock of the controller, given the inputs present at that edge.
    task automatic model_step(input logic [7:0] irq_v, input logic [7:0] pid,
                              input logic [7:0] dat, input logic strb);
        logic [7:0] rise;
        logic [7:0] elig;
        logic       ack;
        rise = irq_v & ~m_prev;
        ack  = strb && (pid == 8'h23);
        elig = m_pend & m_mask;
        if (ack && m_mode == MODE_SERV) m_pend[m_cur] = 1'b0;
        m_pend = m_pend | rise;
        case (m_mode)
            MODE_IDLE: begin
                if (elig != 8'h00) begin
                    m_cur  = lowest(elig);
                    m_mode = MODE_SERV;
                end
            end
            MODE_SERV: begin
                if (ack) begin
                    m_mode = MODE_GAP;
                    m_gap  = GAP_CYCLES;
                end else if (!m_mask[m_cur]) begin
                    m_mode = MODE_IDLE;
                end
            end
            default: begin
                m_gap = m_gap - 1;
                if (m_gap == 0) m_mode = MODE_IDLE;
            end
        endcase
        if (strb && pid == 8'h20) m_mask = dat;
        m_prev = irq_v;
    endtask

    // ------------------------------------------------------------------
    // Stimulus helpers (called just after a rising edge)
    // ------------------------------------------------------------------
    task automatic cycle(input logic [7:0] irq_v, input logic [7:0] pid,
                         input logic [7:0] dat, input logic strb);
        IRQ      = irq_v;
        PORT_ID  = pid;
        OUT_PORT = dat;
        IO_STRB  = strb;
        #1;
        check("in_sel", {7'b0, IN_SEL}, {7'b0, exp_sel(pid)});
        check("in_data", IN_DATA, exp_read(pid));
        @(posedge CLK);
        model_step(irq_v, pid, dat, strb);
        #1;
        check("int", {7'b0, INT}, {7'b0, (m_mode == MODE_SERV)});
    endtask

    task automatic idle(input logic [7:0] irq_v);
        cycle(irq_v, 8'h00, 8'h00, 1'b0);
    endtask

    task automatic peek(input string tag, input logic [7:0] pid, input logic [7:0] exp);
        IO_STRB = 1'b0;
        PORT_ID = pid;
        #1;
        check(tag, IN_DATA, exp);
    endtask

    task automatic do_reset(input logic [7:0] irq_v);
        IRQ      = irq_v;
        IO_STRB  = 1'b0;
        PORT_ID  = 8'h00;
        OUT_PORT = 8'h00;
        RESET_N  = 1'b0;
        @(posedge CLK);
        @(posedge CLK);
        #1;
        RESET_N = 1'b1;
        model_reset();
        check("reset_int", {7'b0, INT}, 8'h00);
    endtask

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    initial begin
        logic [7:0] irq_r;
        logic [7:0] pid_r;
        int         sel;

        model_reset();
        do_reset(8'h00);
        peek("reset_mask", 8'h20, 8'h00);
        peek("reset_stat", 8'h21, 8'h00);
        peek("reset_pend", 8'h22, 8'h00);

        // 1: masked source latches pending but cannot raise INT
        idle(8'h00);
        idle(8'h08);
        idle(8'h00);
        idle(8'h00);
        check("t1_int_masked", {7'b0, INT}, 8'h00);
        peek("t1_pend", 8'h22, 8'h08);
        cycle(8'h00, 8'h20, 8'h08, 1'b1);
        check("t1_int_w", {7'b0, INT}, 8'h00);
        idle(8'h00);
        check("t1_int_on", {7'b0, INT}, 8'h01);
        peek("t1_stat", 8'h21, 8'h83);
        cycle(8'h00, 8'h23, 8'h00, 1'b1);
        idle(8'h00);
        idle(8'h00);

        // 2: priority, gap after ack, second source next
        cycle(8'h00, 8'h20, 8'hFF, 1'b1);
        idle(8'h22);
        idle(8'h22);
        peek("t2_stat1", 8'h21, 8'h81);
        cycle(8'h22, 8'h23, 8'h5A, 1'b1);
        check("t2_gap0", {7'b0, INT}, 8'h00);
        idle(8'h22);
        check("t2_gap1", {7'b0, INT}, 8'h00);
        idle(8'h22);
        check("t2_gap2", {7'b0, INT}, 8'h00);
        idle(8'h22);
        check("t2_reassert", {7'b0, INT}, 8'h01);
        peek("t2_stat5", 8'h21, 8'h85);
        cycle(8'h22, 8'h23, 8'h00, 1'b1);
        for (int k = 0; k < 4; k++) idle(8'h22);
        check("t2_int_off", {7'b0, INT}, 8'h00);
        peek("t2_pend", 8'h22, 8'h00);
        idle(8'h00);

        // 3: re-rise in the ack cycle keeps the source pending
        idle(8'h02);
        idle(8'h00);
        check("t3_int", {7'b0, INT}, 8'h01);
        cycle(8'h02, 8'h23, 8'h00, 1'b1);
        peek("t3_pend", 8'h22, 8'h02);
        idle(8'h00);
        idle(8'h00);
        idle(8'h00);
        check("t3_reassert", {7'b0, INT}, 8'h01);
        peek("t3_stat", 8'h21, 8'h81);
        cycle(8'h00, 8'h23, 8'h00, 1'b1);
        idle(8'h00);
        idle(8'h00);

        // 4: masking the active source withdraws INT
        idle(8'h04);
        idle(8'h00);
        peek("t4_stat", 8'h21, 8'h82);
        cycle(8'h00, 8'h20, 8'hFB, 1'b1);
        idle(8'h00);
        check("t4_withdrawn", {7'b0, INT}, 8'h00);
        peek("t4_pend", 8'h22, 8'h04);
        cycle(8'h00, 8'h20, 8'hFF, 1'b1);
        idle(8'h00);
        check("t4_return", {7'b0, INT}, 8'h01);
        cycle(8'h00, 8'h23, 8'h00, 1'b1);
        idle(8'h00);
        idle(8'h00);

        // 5: source high through reset release, ack in IDLE
        do_reset(8'h01);
        idle(8'h01);
        idle(8'h01);
        peek("t5_pend", 8'h22, 8'h00);
        cycle(8'h01, 8'h23, 8'h00, 1'b1);
        peek("t5_stat", 8'h21, 8'h00);
        peek("t5_pend2", 8'h22, 8'h00);

        // Randomized phase
        irq_r = 8'h01;
        for (int n = 0; n < 1500; n++) begin
            irq_r = irq_r ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
            sel   = $urandom_range(0, 5);
            case (sel)
                0:       pid_r = 8'h20;
                1:       pid_r = 8'h21;
                2:       pid_r = 8'h22;
                3, 4:    pid_r = 8'h23;
                default: pid_r = 8'($urandom);
            endcase
            cycle(irq_r, pid_r, 8'($urandom), ($urandom_range(0, 2) == 0));
        end

        // 6: asynchronous reset while INT is high
        cycle(8'h00, 8'h20, 8'hFF, 1'b1);
        idle(8'h00);
        idle(8'h00);
        idle(8'h00);
        idle(8'h00);
        idle(8'h10);
        idle(8'h00);
        check("t6_int_pre", {7'b0, INT}, 8'h01);
        #2;
        RESET_N = 1'b0;
        #1;
        check("t6_int_async", {7'b0, INT}, 8'h00);
        PORT_ID = 8'h20;
        #1;
        check("t6_mask", IN_DATA, 8'h00);
        check("t6_sel", {7'b0, IN_SEL}, 8'h01);
        @(posedge CLK);
        #1;
        RESET_N = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
